game_session_ctrl: RTL and testbench
====================================

// Module: game_session_ctrl
// PURPOSE
//  Parametrised game-flow controller for N players. Sits between the keyboard
//  keycode export, the per-player sprite controllers and the gem/elevator
//  controllers. Sequences title -> play -> pause/death/win/over, tracks shared
//  lives and the elapsed level time, and issues the one-cycle revive pulse
//  that resets the level-state controllers.
// PARAMETERS
//  NUM_PLAYERS     2      players tracked (width of dead/exit vectors)
//  LIVES           3      lives loaded on start/restart (1..2**LIVES_W-1)
//  LIVES_W         2      width of lives counter
//  TIME_W          10     width of elapsed-seconds counter
//  FRAMES_PER_SEC  60     frame pulses per elapsed second
//  DEATH_FRAMES    60     frame pulses spent in DYING before respawn/over
//  START_KEY       8'h28  keycode for start/restart (Enter)
//  PAUSE_KEY       8'h29  keycode for pause toggle (Esc)
// PORTS
//  Clk            in   1            system clock (50 MHz)
//  Reset_n        in   1            synchronous reset, active low
//  frame_clk      in   1            level frame clock (~VGA_VS); rising edge = frame
//  keycode        in   8            current keycode from NIOS
//  player_dead    in   NUM_PLAYERS  per-player death flag (level)
//  player_at_exit in   NUM_PLAYERS  per-player standing on own exit door (level)
//  state          out  3            0 IDLE,1 REVIVE,2 PLAY,3 PAUSE,4 DYING,5 OVER,6 WIN
//  revive         out  1            1-cycle pulse; resets level controllers
//  play_en        out  1            1 only in PLAY; gates player/elevator motion
//  lives          out  LIVES_W      lives remaining
//  elapsed_sec    out  TIME_W       seconds played, saturating
//  gameover       out  1            1 in OVER
//  gamewin        out  1            1 in WIN
// BEHAVIOUR
//  Reset (Reset_n=0 at posedge): state=IDLE, revive=0, play_en=0, lives=LIVES,
//   elapsed_sec=0, gameover=gamewin=0, frame/death counters=0, key/frame regs=0.
//   Reset mid-operation aborts any state; no revive pulse is issued.
//  frame_pulse: frame_clk registered once; pulse = cur & ~prev (1 Clk wide).
//  Key events: start_ev = (keycode==START_KEY)&&(prev_keycode!=START_KEY);
//   pause_ev likewise. A held key gives one event. prev_keycode resets to 0.
//  All outputs registered; decode directly from state (1-cycle latency from input).
//  IDLE : start_ev -> REVIVE; lives<=LIVES, elapsed_sec<=0, frame_cnt<=0.
//  REVIVE: exactly one Clk; revive=1 in this state only; -> PLAY.
//  PLAY : priority in same cycle: (1) |player_dead -> DYING, lives<=lives-1,
//   death_cnt<=0; (2) &player_at_exit -> WIN; (3) pause_ev -> PAUSE.
//   Else on frame_pulse: frame_cnt==FRAMES_PER_SEC-1 ? (frame_cnt<=0,
//   elapsed_sec+1 saturating at all-ones) : frame_cnt+1.
//   Frame pulse coinciding with leaving PLAY is not counted.
//  PAUSE: counters frozen; pause_ev -> PLAY (frame_cnt retained); start_ev ignored.
//  DYING: death_cnt counts frame pulses; at DEATH_FRAMES-th pulse:
//   lives==0 -> OVER else -> REVIVE (elapsed_sec kept). Inputs ignored.
//  OVER/WIN: hold; start_ev -> REVIVE with lives<=LIVES, elapsed_sec<=0, frame_cnt<=0.
//  lives never underflows (DYING entered only from PLAY with lives>=1 invariant).
//  Unused state encoding 7 -> IDLE next cycle.
// TESTING
//  Reset, keycode=8'h28 held 100 cycles -> one REVIVE cycle (revive=1 once), PLAY, lives=3.
//  PLAY, 120 frame_clk rising edges -> elapsed_sec=2; 8'h29 -> PAUSE, 60 edges -> still 2.
//  PLAY, player_dead=2'b01 and player_at_exit=2'b11 same cycle -> DYING, lives=2;
//   after 60 frame edges -> REVIVE pulse then PLAY, elapsed_sec unchanged.
//  Three deaths from lives=3 -> after third DYING, OVER, gameover=1; 8'h28 -> REVIVE, lives=3, elapsed_sec=0.
//  TIME_W=2, 300 frame edges -> elapsed_sec saturates at 3.
//  Reset_n=0 for 1 cycle during DYING -> IDLE, lives=3, no revive pulse.

Source files
------------

// File: rtl/game_session_ctrl_if.sv
// Bundle of the game-flow controller's level-side signals: keycode, frame clock and
// per-player status go in; state, revive pulse, play enable, lives, time and end flags come out.
// master drives the inputs (keyboard/level side); slave is the session controller itself.
interface game_session_ctrl_if #(
    parameter int NUM_PLAYERS = 2,
    parameter int LIVES_W     = 2,
    parameter int TIME_W      = 10
);
    logic                   frame_clk;
    logic [7:0]             keycode;
    logic [NUM_PLAYERS-1:0] player_dead;
    logic [NUM_PLAYERS-1:0] player_at_exit;
    logic [2:0]             state;
    logic                   revive;
    logic                   play_en;
    logic [LIVES_W-1:0]     lives;
    logic [TIME_W-1:0]      elapsed_sec;
    logic                   gameover;
    logic                   gamewin;

    modport master (
        output frame_clk, keycode, player_dead, player_at_exit,
        input  state, revive, play_en, lives, elapsed_sec, gameover, gamewin
    );

    modport slave (
        input  frame_clk, keycode, player_dead, player_at_exit,
        output state, revive, play_en, lives, elapsed_sec, gameover, gamewin
    );
endinterface

// File: rtl/game_session_ctrl.sv
// Game-flow FSM: IDLE -> REVIVE -> PLAY -> PAUSE/DYING/WIN/OVER, shared lives, elapsed seconds.
// Latency: every output is decoded from registered state, one Clk after the causing input.
// No backpressure: key and frame events are edge-detected and consumed in the cycle they occur.
// Ports: Clk, Reset_n (sync, active low), sess_if (slave modport of game_session_ctrl_if).
module game_session_ctrl #(
    parameter int         NUM_PLAYERS    = 2,
    parameter int         LIVES          = 3,
    parameter int         LIVES_W        = 2,
    parameter int         TIME_W         = 10,
    parameter int         FRAMES_PER_SEC = 60,
    parameter int         DEATH_FRAMES   = 60,
    parameter logic [7:0] START_KEY      = 8'h28,
    parameter logic [7:0] PAUSE_KEY      = 8'h29
) (
    input  logic                Clk,
    input  logic                Reset_n,
    game_session_ctrl_if.slave  sess_if
);
    localparam int FCNT_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam int DCNT_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REVIVE = 3'd1,
        ST_PLAY   = 3'd2,
        ST_PAUSE  = 3'd3,
        ST_DYING  = 3'd4,
        ST_OVER   = 3'd5,
        ST_WIN    = 3'd6
    } state_t;

    state_t             state_q;
    logic [LIVES_W-1:0] lives_q;
    logic [TIME_W-1:0]  elapsed_q;
    logic [FCNT_W-1:0]  frame_cnt_q;
    logic [DCNT_W-1:0]  death_cnt_q;
    logic               frame_q;
    logic               frame_prev_q;
    logic [7:0]         prev_keycode_q;

    logic start_ev;
    logic pause_ev;
    logic frame_pulse;

    // One event per key press: a held key only fires on the cycle it first appears.
    assign start_ev    = (sess_if.keycode == START_KEY) && (prev_keycode_q != START_KEY);
    assign pause_ev    = (sess_if.keycode == PAUSE_KEY) && (prev_keycode_q != PAUSE_KEY);
    // frame_clk is asynchronous to Clk; its registered copy is edge-detected to a 1-Clk pulse.
    assign frame_pulse = frame_q & ~frame_prev_q;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q        <= ST_IDLE;
            lives_q        <= LIVES_W'(LIVES);
            elapsed_q      <= '0;
            frame_cnt_q    <= '0;
            death_cnt_q    <= '0;
            frame_q        <= 1'b0;
            frame_prev_q   <= 1'b0;
            prev_keycode_q <= 8'h00;
        end else begin
            frame_q        <= sess_if.frame_clk;
            frame_prev_q   <= frame_q;
            prev_keycode_q <= sess_if.keycode;

            case (state_q)
                ST_IDLE, ST_OVER, ST_WIN: begin
                    if (start_ev) begin
                        state_q     <= ST_REVIVE;
                        lives_q     <= LIVES_W'(LIVES);
                        elapsed_q   <= '0;
                        frame_cnt_q <= '0;
                    end
                end
                ST_REVIVE: state_q <= ST_PLAY;
                ST_PLAY: begin
                    // Death beats reaching the exits, which beats pausing; a frame pulse
                    // in a cycle that leaves PLAY is dropped.
                    if (|sess_if.player_dead) begin
                        state_q     <= ST_DYING;
                        lives_q     <= lives_q - LIVES_W'(1);
                        death_cnt_q <= '0;
                    end else if (&sess_if.player_at_exit) begin
                        state_q <= ST_WIN;
                    end else if (pause_ev) begin
                        state_q <= ST_PAUSE;
                    end else if (frame_pulse) begin
                        if (frame_cnt_q == FCNT_W'(FRAMES_PER_SEC - 1)) begin
                            frame_cnt_q <= '0;
                            if (elapsed_q != '1) begin
                                elapsed_q <= elapsed_q + TIME_W'(1);
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (pause_ev) begin
                        state_q <= ST_PLAY;
                    end
                end
                ST_DYING: begin
                    if (frame_pulse) begin
                        if (death_cnt_q == DCNT_W'(DEATH_FRAMES - 1)) begin
                            death_cnt_q <= '0;
                            state_q     <= (lives_q == '0) ? ST_OVER : ST_REVIVE;
                        end else begin
                            death_cnt_q <= death_cnt_q + DCNT_W'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sess_if.state       = state_q;
    assign sess_if.revive      = (state_q == ST_REVIVE);
    assign sess_if.play_en     = (state_q == ST_PLAY);
    assign sess_if.lives       = lives_q;
    assign sess_if.elapsed_sec = elapsed_q;
    assign sess_if.gameover    = (state_q == ST_OVER);
    assign sess_if.gamewin     = (state_q == ST_WIN);
endmodule

// File: tb/tb_game_session_ctrl.sv
// Scoreboard bench for game_session_ctrl: dut1 (TIME_W=10) walks the full game flow,
// dut2 (TIME_W=2) plays continuously to exercise elapsed_sec saturation.
// Every change of a DUT's output snapshot is popped against its expected queue.
module tb_game_session_ctrl;
    logic Clk = 1'b0;
    logic Reset_n;
    logic rst2_n;

    always #5 Clk = ~Clk;

    game_session_ctrl_if #(.NUM_PLAYERS(2), .LIVES_W(2), .TIME_W(10)) ifc1 ();
    game_session_ctrl_if #(.NUM_PLAYERS(2), .LIVES_W(2), .TIME_W(2))  ifc2 ();

    game_session_ctrl #(.TIME_W(10)) dut1 (.Clk(Clk), .Reset_n(Reset_n), .sess_if(ifc1.slave));
    game_session_ctrl #(.TIME_W(2))  dut2 (.Clk(Clk), .Reset_n(rst2_n),  .sess_if(ifc2.slave));

    typedef struct packed {
        logic [2:0] st;
        logic       rv;
        logic       pe;
        logic [1:0] lv;
        logic [9:0] el;
        logic       go;
        logic       gw;
    } snap_t;

    snap_t q1[$];
    snap_t q2[$];
    snap_t prev1, prev2;
    int    tests   = 0;
    int    fails   = 0;
    int    rev_cnt = 0;
    bit    mon_en  = 1'b0;

    function automatic snap_t mk(int st, int lv, int el);
        snap_t s;
        s.st = 3'(st);
        s.rv = (st == 1);
        s.pe = (st == 2);
        s.lv = 2'(lv);
        s.el = 10'(el);
        s.go = (st == 5);
        s.gw = (st == 6);
        return s;
    endfunction

    function automatic snap_t cur1();
        snap_t s;
        s = {ifc1.state, ifc1.revive, ifc1.play_en, ifc1.lives, ifc1.elapsed_sec,
             ifc1.gameover, ifc1.gamewin};
        return s;
    endfunction

    function automatic snap_t cur2();
        snap_t s;
        s = {ifc2.state, ifc2.revive, ifc2.play_en, ifc2.lives, {8'd0, ifc2.elapsed_sec},
             ifc2.gameover, ifc2.gamewin};
        return s;
    endfunction

    function automatic string fmt(snap_t s);
        return $sformatf("st=%0d rv=%0b pe=%0b lv=%0d el=%0d go=%0b gw=%0b",
                         s.st, s.rv, s.pe, s.lv, s.el, s.go, s.gw);
    endfunction

    task automatic check_snap(string name, snap_t got, snap_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got {%s} expected {%s}", name, fmt(got), fmt(exp));
        end
    endtask

    task automatic check_int(string name, int got, int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitors: any change in a DUT's observable outputs must match the next queued entry.
    always @(negedge Clk) begin
        snap_t c1, c2;
        c1 = cur1();
        c2 = cur2();
        if (mon_en && (c1 !== prev1)) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut1_unexpected: got {%s} with nothing expected", fmt(c1));
            end else begin
                check_snap("dut1_seq", c1, q1.pop_front());
            end
        end
        if (mon_en && (c2 !== prev2)) begin
            if (q2.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL dut2_unexpected: got {%s} with nothing expected", fmt(c2));
            end else begin
                check_snap("dut2_seq", c2, q2.pop_front());
            end
        end
        prev1 = c1;
        prev2 = c2;
        if (ifc1.revive === 1'b1) rev_cnt++;
    end

    task automatic cyc(int n = 1);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic frame_edges(int n);
        for (int i = 0; i < n; i++) begin
            ifc1.frame_clk = 1'b1;
            ifc2.frame_clk = 1'b1;
            cyc(2);
            ifc1.frame_clk = 1'b0;
            ifc2.frame_clk = 1'b0;
            cyc(2);
        end
    endtask

    task automatic key1(logic [7:0] k, int hold);
        ifc1.keycode = k;
        cyc(hold);
        ifc1.keycode = 8'h00;
        cyc(2);
    endtask

    task automatic die1();
        ifc1.player_dead = 2'b01;
        cyc(2);
        ifc1.player_dead = 2'b00;
        cyc(1);
    endtask

    initial begin
        int base;
        Reset_n = 1'b0;
        rst2_n  = 1'b0;
        ifc1.frame_clk = 1'b0; ifc1.keycode = 8'h00;
        ifc1.player_dead = 2'b00; ifc1.player_at_exit = 2'b00;
        ifc2.frame_clk = 1'b0; ifc2.keycode = 8'h00;
        ifc2.player_dead = 2'b00; ifc2.player_at_exit = 2'b00;
        cyc(3);
        Reset_n = 1'b1;
        rst2_n  = 1'b1;
        cyc(1);
        check_snap("reset_dut1", cur1(), mk(0, 3, 0));
        check_snap("reset_dut2", cur2(), mk(0, 3, 0));
        mon_en = 1'b1;

        // Held Enter: exactly one REVIVE cycle, then PLAY with full lives.
        q1.push_back(mk(1, 3, 0)); q1.push_back(mk(2, 3, 0));
        q2.push_back(mk(1, 3, 0)); q2.push_back(mk(2, 3, 0));
        q2.push_back(mk(2, 3, 1)); q2.push_back(mk(2, 3, 2)); q2.push_back(mk(2, 3, 3));
        base = rev_cnt;
        ifc1.keycode = 8'h28;
        ifc2.keycode = 8'h28;
        cyc(100);
        ifc1.keycode = 8'h00;
        ifc2.keycode = 8'h00;
        cyc(2);
        check_int("revive_once", rev_cnt - base, 1);

        // 120 frames in PLAY -> two seconds.
        q1.push_back(mk(2, 3, 1)); q1.push_back(mk(2, 3, 2));
        frame_edges(120);
        check_int("elapsed_120", int'(ifc1.elapsed_sec), 2);

        // Pause freezes time and ignores Enter; Esc resumes.
        q1.push_back(mk(3, 3, 2));
        key1(8'h29, 3);
        key1(8'h28, 3);
        frame_edges(60);
        check_int("pause_freeze", int'(ifc1.elapsed_sec), 2);
        q1.push_back(mk(2, 3, 2));
        key1(8'h29, 3);

        // Death and full exit in the same cycle: death wins.
        q1.push_back(mk(4, 2, 2));
        ifc1.player_at_exit = 2'b11;
        die1();
        ifc1.player_at_exit = 2'b00;
        q1.push_back(mk(1, 2, 2)); q1.push_back(mk(2, 2, 2));
        frame_edges(60);
        check_int("elapsed_kept", int'(ifc1.elapsed_sec), 2);

        // Remaining two lives lost -> OVER.
        q1.push_back(mk(4, 1, 2));
        die1();
        q1.push_back(mk(1, 1, 2)); q1.push_back(mk(2, 1, 2));
        frame_edges(60);
        q1.push_back(mk(4, 0, 2));
        die1();
        q1.push_back(mk(5, 0, 2));
        frame_edges(60);
        check_int("gameover", int'(ifc1.gameover), 1);

        // Restart from OVER reloads lives and clears time.
        q1.push_back(mk(1, 3, 0)); q1.push_back(mk(2, 3, 0));
        key1(8'h28, 3);

        // Exits and Esc together: WIN beats pause; Enter restarts from WIN.
        q1.push_back(mk(6, 3, 0));
        ifc1.player_at_exit = 2'b11;
        key1(8'h29, 2);
        ifc1.player_at_exit = 2'b00;
        cyc(2);
        q1.push_back(mk(1, 3, 0)); q1.push_back(mk(2, 3, 0));
        key1(8'h28, 2);

        // Reset during DYING: back to IDLE, lives reloaded, no revive pulse.
        q1.push_back(mk(4, 2, 0));
        die1();
        frame_edges(10);
        q1.push_back(mk(0, 3, 0));
        base = rev_cnt;
        Reset_n = 1'b0;
        cyc(1);
        Reset_n = 1'b1;
        cyc(5);
        check_int("no_revive_on_reset", rev_cnt - base, 0);

        // dut2 has now seen well over 300 frames in PLAY: saturated at 3.
        check_int("elapsed_saturated", int'(ifc2.elapsed_sec), 3);
        cyc(5);
        check_int("dut1_queue_drained", q1.size(), 0);
        check_int("dut2_queue_drained", q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
